// File: rtl/bike_sampler_bram_loader.sv
// bike_sampler_bram_loader
//   Fills the two-polynomial shared BRAM during the sampling phase. 32-bit
//   random words arrive over a valid/ready handshake. Polynomial 0 is written
//   through sample port 0 and polynomial 1 through sample port 1. Unused bits
//   of each polynomial's final word are masked off.
//
// Ports
//   clk, resetn         clock, synchronous active-high reset
//   start               one-cycle request to fill both polynomials
//   rnd_valid/ready     random word handshake, rnd_data is the word
//   sampling            selects the sampling ports of the shared BRAM
//   ren0/1_samp         read enables, always 0
//   wen0/1_samp         write enables, ports 0 and 1
//   addr0/1_samp        write addresses
//   din0/1_samp         write data
//   busy                fill in progress
//   done                one-cycle pulse after the final write
//   hw0, hw1            Hamming weight of each written polynomial
//                       (present only with BIKE_SAMPLER_HW_COUNT_EN defined)
module bike_sampler_bram_loader #(
    parameter int unsigned R_BITS    = 12323,
    parameter int unsigned DWORDS    = (R_BITS + 31) / 32,
    parameter int unsigned LOGDWORDS = 9
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [31:0]          rnd_data,
    output logic                 sampling,
    output logic                 ren0_samp,
    output logic                 ren1_samp,
    output logic                 wen0_samp,
    output logic                 wen1_samp,
    output logic [LOGDWORDS-1:0] addr0_samp,
    output logic [LOGDWORDS-1:0] addr1_samp,
    output logic [31:0]          din0_samp,
    output logic [31:0]          din1_samp,
    output logic                 busy,
    output logic                 done
`ifdef BIKE_SAMPLER_HW_COUNT_EN
   ,output logic [$clog2(R_BITS+1)-1:0] hw0,
    output logic [$clog2(R_BITS+1)-1:0] hw1
`endif
);

    localparam int unsigned          TAIL      = R_BITS % 32;
    localparam logic [31:0]          LAST_MASK = (TAIL == 0) ? '1 : ((32'd1 << TAIL) - 32'd1);
    localparam logic [LOGDWORDS-1:0] LAST_IDX  = LOGDWORDS'(DWORDS - 1);

    typedef enum logic [2:0] {IDLE, FILL0, FILL1, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [LOGDWORDS-1:0]  cnt_q, cnt_d;
    logic                  sampling_q, sampling_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wen0_q, wen0_d, wen1_q, wen1_d;
    logic [LOGDWORDS-1:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0]           din0_q, din0_d, din1_q, din1_d;
    logic                  accept;
    logic [31:0]           masked;

`ifdef BIKE_SAMPLER_HW_COUNT_EN
    logic [$clog2(R_BITS+1)-1:0] hw0_q, hw0_d, hw1_q, hw1_d;

    function automatic logic [5:0] popcount32(input logic [31:0] w);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + 6'(w[i]);
        end
        return n;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        din0_d     = din0_q;
        din1_d     = din1_q;
        wen0_d     = 1'b0;
        wen1_d     = 1'b0;
        // done is registered from the DONE state, so it lands three cycles
        // after the final accept while the last write has already retired.
        done_d     = (state_q == DONE);
`ifdef BIKE_SAMPLER_HW_COUNT_EN
        hw0_d      = hw0_q;
        hw1_d      = hw1_q;
`endif
        rnd_ready  = (state_q == FILL0) || (state_q == FILL1);
        accept     = rnd_ready && rnd_valid;
        masked     = (cnt_q == LAST_IDX) ? (rnd_data & LAST_MASK) : rnd_data;

        unique case (state_q)
            IDLE: begin
                // busy_q is still high during the done pulse, which blocks
                // a start coinciding with it.
                if (start && !busy_q) begin
                    state_d = FILL0;
                    cnt_d   = '0;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
                    hw0_d   = '0;
                    hw1_d   = '0;
`endif
                end
            end
            FILL0: begin
                if (accept) begin
                    wen0_d  = 1'b1;
                    addr0_d = cnt_q;
                    din0_d  = masked;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
                    hw0_d   = hw0_q + $bits(hw0_q)'(popcount32(masked));
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = FILL1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            FILL1: begin
                if (accept) begin
                    wen1_d  = 1'b1;
                    addr1_d = cnt_q;
                    din1_d  = masked;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
                    hw1_d   = hw1_q + $bits(hw1_q)'(popcount32(masked));
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Held through the done pulse, dropped the cycle after.
        sampling_d = (state_d != IDLE) || (state_q == DONE);
        busy_d     = sampling_d;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sampling_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wen0_q     <= 1'b0;
            wen1_q     <= 1'b0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            din0_q     <= '0;
            din1_q     <= '0;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
            hw0_q      <= '0;
            hw1_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sampling_q <= sampling_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wen0_q     <= wen0_d;
            wen1_q     <= wen1_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            din0_q     <= din0_d;
            din1_q     <= din1_d;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
            hw0_q      <= hw0_d;
            hw1_q      <= hw1_d;
`endif
        end
    end

    assign sampling   = sampling_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ren0_samp  = 1'b0;
    assign ren1_samp  = 1'b0;
    assign wen0_samp  = wen0_q;
    assign wen1_samp  = wen1_q;
    assign addr0_samp = addr0_q;
    assign addr1_samp = addr1_q;
    assign din0_samp  = din0_q;
    assign din1_samp  = din1_q;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
    assign hw0        = hw0_q;
    assign hw1        = hw1_q;
`endif

endmodule

// File: tb/tb_bike_sampler_bram_loader.sv
// Testbench for bike_sampler_bram_loader (default parameters, R_BITS = 12323).
module tb_bike_sampler_bram_loader;

    localparam int NW = 386;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [31:0] rnd_data;
    logic        sampling;
    logic        ren0_samp, ren1_samp;
    logic        wen0_samp, wen1_samp;
    logic [8:0]  addr0_samp, addr1_samp;
    logic [31:0] din0_samp, din1_samp;
    logic        busy;
    logic        done;
`ifdef BIKE_SAMPLER_HW_COUNT_EN
    logic [13:0] hw0, hw1;
`endif

    bike_sampler_bram_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .sampling   (sampling),
        .ren0_samp  (ren0_samp),
        .ren1_samp  (ren1_samp),
        .wen0_samp  (wen0_samp),
        .wen1_samp  (wen1_samp),
        .addr0_samp (addr0_samp),
        .addr1_samp (addr1_samp),
        .din0_samp  (din0_samp),
        .din1_samp  (din1_samp),
        .busy       (busy),
        .done       (done)
`ifdef BIKE_SAMPLER_HW_COUNT_EN
       ,.hw0        (hw0),
        .hw1        (hw1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // write scoreboard
    bit sb_on = 0;
    int mode  = 0;
    bit seen0 [NW];
    bit seen1 [NW];
    int wr0   = 0;
    int wr1   = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        exp_wen0;
        logic [8:0]  exp_addr0;
        logic [31:0] exp_din0;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mode 0: word = global index, mode 1: all ones; last word keeps low 3 bits
    function automatic logic [31:0] exp_din(input int port, input int addr, input int m);
        logic [31:0] v;
        v = (m == 1) ? 32'hFFFF_FFFF : 32'(port * NW + addr);
        if (addr == NW - 1) v = v & 32'h0000_0007;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wen0_samp && wen1_samp) chk("wen_exclusive", 32'(1), 32'(0));
        if (sb_on && wen0_samp) begin
            chk("wr0_addr_range", 32'(addr0_samp < NW), 32'(1));
            chk("wr0_before_wr1", 32'(wr1), 32'(0));
            if (addr0_samp < NW) begin
                chk("wr0_no_dup", 32'(seen0[addr0_samp]), 32'(0));
                chk("wr0_din", din0_samp, exp_din(0, int'(addr0_samp), mode));
                seen0[addr0_samp] = 1'b1;
            end
            wr0++;
        end
        if (sb_on && wen1_samp) begin
            chk("wr1_addr_range", 32'(addr1_samp < NW), 32'(1));
            chk("wr1_after_wr0", 32'(wr0), 32'(NW));
            if (addr1_samp < NW) begin
                chk("wr1_no_dup", 32'(seen1[addr1_samp]), 32'(0));
                chk("wr1_din", din1_samp, exp_din(1, int'(addr1_samp), mode));
                seen1[addr1_samp] = 1'b1;
            end
            wr1++;
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_outs"},
            {22'd0, sampling, rnd_ready, ren0_samp, ren1_samp, wen0_samp, wen1_samp, busy, done, 2'b00},
            32'd0);
    endtask

    task automatic run_fill(input int m, input bit randv, input bit poke);
        int k         = 0;
        int last_edge = -1;
        int budget    = 0;
        bit acc;
        bit got_done  = 0;
        int ehw0      = 0;
        int ehw1      = 0;
        mode = m;
        for (int a = 0; a < NW; a++) begin
            seen0[a] = 1'b0;
            seen1[a] = 1'b0;
            ehw0 += $countones(exp_din(0, a, m));
            ehw1 += $countones(exp_din(1, a, m));
        end
        wr0 = 0;
        wr1 = 0;
        sb_on = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fill_start_state", {29'd0, sampling, busy, rnd_ready}, 32'd7);
        while (!got_done && budget < 5000) begin
            rnd_valid = (k < 2 * NW) ? (randv ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            rnd_data  = (m == 1) ? 32'hFFFF_FFFF : 32'(k);
            start     = poke && (k == 50);
            acc       = rnd_valid && rnd_ready;
            tick();
            budget++;
            if (acc) begin
                k++;
                if (k == 2 * NW) last_edge = cyc;
            end
            if (done) begin
                got_done = 1;
                chk("done_latency", 32'(cyc - last_edge), 32'd2);
                chk("done_accepts", 32'(k), 32'(2 * NW));
                chk("done_sampling_busy", {30'd0, sampling, busy}, 32'd3);
`ifdef BIKE_SAMPLER_HW_COUNT_EN
                chk("hw0", 32'(hw0), 32'(ehw0));
                chk("hw1", 32'(hw1), 32'(ehw1));
                if (m == 1) chk("hw_all_ones", 32'(hw0 + hw1), 32'd24646);
`endif
            end else begin
                chk("fill_sampling_busy", {30'd0, sampling, busy}, 32'd3);
            end
        end
        if (!got_done) chk("fill_timeout", 32'd0, 32'd1);
        // optional start on the done cycle must be ignored
        rnd_valid = 1'b0;
        start = poke;
        tick();
        start = 1'b0;
        chk_quiet("after_done");
        repeat (3) begin
            tick();
            chk_quiet("idle_after_done");
        end
        sb_on = 0;
        chk("wr0_count", 32'(wr0), 32'(NW));
        chk("wr1_count", 32'(wr1), 32'(NW));
    endtask

    initial begin
        int acc_cnt;
        int budget;
        resetn    = 1'b1;
        start     = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = 32'd0;

        vecs[0] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 9'd0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 32'h1111_1111, 1'b0, 9'd0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 9'd1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 9'd2, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 9'd2, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 9'd2, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 9'd3, 32'h0000_0000};
        vecs[7] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 9'd4, 32'hFFFF_FFFF};
        vecs[8] = '{1'b0, 1'b1, 32'h8000_0001, 1'b1, 9'd5, 32'h8000_0001};

        // reset, then idle
        repeat (2) tick();
        resetn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_quiet("reset_idle");
        end
        chk("reset_addr_din", {addr0_samp, addr1_samp, 14'd0}, 32'd0);
        chk("reset_din0", din0_samp, 32'd0);
        chk("reset_din1", din1_samp, 32'd0);

        // start with no random words: state held for 50 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("stall_state",
                {27'd0, sampling, busy, rnd_ready, wen0_samp, wen1_samp}, 32'b11100);
        end

        // table of handshake vectors in FILL0
        for (int i = 0; i < 9; i++) begin
            start     = vecs[i].start;
            rnd_valid = vecs[i].valid;
            rnd_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_wen0", i), 32'(wen0_samp), 32'(vecs[i].exp_wen0));
            chk($sformatf("vec%0d_addr0", i), 32'(addr0_samp), 32'(vecs[i].exp_addr0));
            chk($sformatf("vec%0d_din0", i), din0_samp, vecs[i].exp_din0);
            chk($sformatf("vec%0d_ctl", i), {29'd0, rnd_ready, sampling, wen1_samp}, 32'b110);
        end
        start     = 1'b0;
        rnd_valid = 1'b0;
        resetn    = 1'b1;
        tick();
        resetn    = 1'b0;
        chk_quiet("reset_after_vecs");

        // full fill, indexed data, start poked mid-fill and on done
        run_fill(0, 1'b0, 1'b1);

        // full fill, all-ones data, random back-pressure
        run_fill(1, 1'b1, 1'b0);

        // reset after 100 accepts in FILL0
        start = 1'b1;
        tick();
        start = 1'b0;
        acc_cnt = 0;
        budget  = 0;
        while (acc_cnt < 100 && budget < 500) begin
            rnd_valid = 1'b1;
            rnd_data  = 32'(acc_cnt);
            if (rnd_ready) acc_cnt++;
            tick();
            budget++;
        end
        chk("midreset_accepts", 32'(acc_cnt), 32'd100);
        chk("midreset_last_addr", 32'(addr0_samp), 32'd99);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        rnd_valid = 1'b0;
        chk_quiet("midreset");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd_valid = 1'b1;
        rnd_data  = 32'h0000_0055;
        tick();
        rnd_valid = 1'b0;
        chk("restart_write", {22'd0, wen0_samp, addr0_samp}, {22'd0, 1'b1, 9'd0});
        chk("restart_din", din0_samp, 32'h0000_0055);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
